// File: rtl/cfg_disp_pkg.sv
// Shared types and sizing for the config dispatcher.
// Field widths, per-field beat counts and the queued config-set bundle.
package cfg_disp_pkg;

  localparam int HWIDTH      = 32;
  localparam int DATA_CWIDTH = 64;
  localparam int WICP_CWIDTH = 64;
  localparam int TMPC_CWIDTH = 32;
  localparam int POST_CWIDTH = 32;
  localparam int CMD_DEPTH   = 4;
  localparam int LVL_W       = $clog2(CMD_DEPTH) + 1;

  localparam int DATA_BEATS = (DATA_CWIDTH + HWIDTH - 1) / HWIDTH;
  localparam int WICP_BEATS = (WICP_CWIDTH + HWIDTH - 1) / HWIDTH;
  localparam int TMPC_BEATS = (TMPC_CWIDTH + HWIDTH - 1) / HWIDTH;
  localparam int POST_BEATS = (POST_CWIDTH + HWIDTH - 1) / HWIDTH;
  localparam int IDX_W      = $clog2(DATA_BEATS + 1);

  typedef enum logic [1:0] {
    SEL_DATA,
    SEL_WICP,
    SEL_TMPC,
    SEL_POST
  } field_sel_e;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RUN
  } state_e;

  typedef struct packed {
    logic [DATA_CWIDTH-1:0] data;
    logic [WICP_CWIDTH-1:0] wicp;
    logic [TMPC_CWIDTH-1:0] tmpc;
    logic [POST_CWIDTH-1:0] post;
  } cfg_set_t;

  function automatic logic [IDX_W-1:0] beats_of(field_sel_e s);
    logic [IDX_W-1:0] n;
    unique case (s)
      SEL_DATA: n = IDX_W'(DATA_BEATS);
      SEL_WICP: n = IDX_W'(WICP_BEATS);
      SEL_TMPC: n = IDX_W'(TMPC_BEATS);
      SEL_POST: n = IDX_W'(POST_BEATS);
    endcase
    return n;
  endfunction

endpackage

// File: rtl/cfg_set_fifo.sv
// Synchronous FIFO of complete config sets.
// Extra pointer bit separates full from empty.
module cfg_set_fifo
  import cfg_disp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  cfg_set_t                 wdata,
  input  logic                     pop,
  output cfg_set_t                 rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  cfg_set_t   mem_q [DEPTH];
  logic [AW:0] wr_q, wr_d;
  logic [AW:0] rd_q, rd_d;
  logic        push_ok;
  logic        pop_ok;

  assign level   = wr_q - rd_q;
  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q + (AW+1)'(push_ok);
    rd_d = rd_q + (AW+1)'(pop_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      if (push_ok) begin
        mem_q[wr_q[AW-1:0]] <= wdata;
      end
    end
  end

endmodule

// File: rtl/cfg_dispatcher.sv
// Assembles host config beats into sets, queues them and
// issues one set at a time to the PE array, paced by cfg_busy.
module cfg_dispatcher
  import cfg_disp_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   host_wvalid,
  output logic                   host_wready,
  input  logic [1:0]             host_wsel,
  input  logic [HWIDTH-1:0]      host_wdata,
  input  logic                   host_wlast,
  output logic                   cfg_valid,
  input  logic                   cfg_busy,
  output logic [DATA_CWIDTH-1:0] cfg_data_data,
  output logic [WICP_CWIDTH-1:0] cfg_wicp_data,
  output logic [TMPC_CWIDTH-1:0] cfg_tmpc_data,
  output logic [POST_CWIDTH-1:0] cfg_post_data,
  output logic [LVL_W-1:0]       fifo_level,
  output logic [15:0]            issued_cnt,
  output logic                   err_overflow
);

  cfg_set_t              shadow_q, shadow_d;
  cfg_set_t              fifo_rdata;
  cfg_set_t              out_q;
  logic [3:0][IDX_W-1:0] idx_q, idx_d;
  logic                  ovf_q, ovf_d;
  logic                  fifo_full, fifo_empty;
  logic                  accept, push, pop;
  field_sel_e            sel;
  state_e                state_q;
  logic                  cfg_valid_q;
  logic [15:0]           issued_cnt_q;

  assign sel    = field_sel_e'(host_wsel);
  assign accept = host_wvalid & host_wready;
  assign push   = accept & host_wlast;
  assign pop    = (state_q == IDLE) & ~fifo_empty & ~cfg_busy;

  always_comb begin
    shadow_d = shadow_q;
    idx_d    = idx_q;
    ovf_d    = ovf_q;
    if (accept) begin
      if (idx_q[sel] < beats_of(sel)) begin
        idx_d[sel] = idx_q[sel] + 1'b1;
        unique case (sel)
          SEL_DATA: shadow_d.data[idx_q[sel]*HWIDTH +: HWIDTH] = host_wdata;
          SEL_WICP: shadow_d.wicp[idx_q[sel]*HWIDTH +: HWIDTH] = host_wdata;
          SEL_TMPC: shadow_d.tmpc = host_wdata;
          SEL_POST: shadow_d.post = host_wdata;
        endcase
      end else begin
        ovf_d = 1'b1;
      end
      // commit pushes shadow_d so the last beat's data is included
      if (host_wlast) begin
        idx_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      idx_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      idx_q    <= idx_d;
      ovf_q    <= ovf_d;
    end
  end

  cfg_set_fifo #(
    .DEPTH (CMD_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (shadow_d),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cfg_valid_q  <= 1'b0;
      out_q        <= '0;
      issued_cnt_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (pop) begin
          out_q       <= fifo_rdata;
          cfg_valid_q <= 1'b1;
          state_q     <= ISSUE;
        end
        ISSUE: if (cfg_busy) begin
          cfg_valid_q <= 1'b0;
          state_q     <= RUN;
        end
        RUN: if (!cfg_busy) begin
          issued_cnt_q <= issued_cnt_q + 16'd1;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign host_wready   = ~fifo_full;
  assign cfg_valid     = cfg_valid_q;
  assign cfg_data_data = out_q.data;
  assign cfg_wicp_data = out_q.wicp;
  assign cfg_tmpc_data = out_q.tmpc;
  assign cfg_post_data = out_q.post;
  assign issued_cnt    = issued_cnt_q;
  assign err_overflow  = ovf_q;

endmodule

// File: tb/tb_cfg_dispatcher.sv
// Scoreboard bench for cfg_dispatcher: a bench-side shadow model
// predicts each committed set, compared when cfg_valid rises.
module tb_cfg_dispatcher;
  import cfg_disp_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        host_wvalid, host_wready, host_wlast;
  logic [1:0]  host_wsel;
  logic [31:0] host_wdata;
  logic        cfg_valid, cfg_busy;
  logic [63:0] cfg_data_data, cfg_wicp_data;
  logic [31:0] cfg_tmpc_data, cfg_post_data;
  logic [2:0]  fifo_level;
  logic [15:0] issued_cnt;
  logic        err_overflow;

  logic hold_busy = 1'b0;
  logic acc_busy  = 1'b0;
  logic auto_en   = 1'b1;
  assign cfg_busy = hold_busy | acc_busy;

  int n_chk  = 0;
  int n_pass = 0;

  cfg_set_t exp_q[$];
  cfg_set_t m_set;
  int       m_idx[4];
  logic     prev_v;

  cfg_dispatcher dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .host_wvalid   (host_wvalid),
    .host_wready   (host_wready),
    .host_wsel     (host_wsel),
    .host_wdata    (host_wdata),
    .host_wlast    (host_wlast),
    .cfg_valid     (cfg_valid),
    .cfg_busy      (cfg_busy),
    .cfg_data_data (cfg_data_data),
    .cfg_wicp_data (cfg_wicp_data),
    .cfg_tmpc_data (cfg_tmpc_data),
    .cfg_post_data (cfg_post_data),
    .fifo_level    (fifo_level),
    .issued_cnt    (issued_cnt),
    .err_overflow  (err_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
  endtask

  task automatic model_beat(input logic [1:0] sel, input logic [31:0] d,
                            input logic last);
    int nb;
    nb = (sel < 2'd2) ? 2 : 1;
    if (m_idx[sel] < nb) begin
      case (sel)
        2'd0: m_set.data[m_idx[sel]*32 +: 32] = d;
        2'd1: m_set.wicp[m_idx[sel]*32 +: 32] = d;
        2'd2: m_set.tmpc = d;
        default: m_set.post = d;
      endcase
      m_idx[sel]++;
    end
    if (last) begin
      exp_q.push_back(m_set);
      for (int i = 0; i < 4; i++) m_idx[i] = 0;
    end
  endtask

  task automatic send_beat(input logic [1:0] sel, input logic [31:0] d,
                           input logic last);
    int n = 0;
    @(negedge clk);
    host_wvalid = 1'b1;
    host_wsel   = sel;
    host_wdata  = d;
    host_wlast  = last;
    while (!host_wready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!host_wready) begin
      chk("wready_timeout", 64'(host_wready), 64'd1);
      host_wvalid = 1'b0;
      host_wlast  = 1'b0;
      return;
    end
    @(posedge clk);
    model_beat(sel, d, last);
    #1;
    host_wvalid = 1'b0;
    host_wlast  = 1'b0;
  endtask

  task automatic wait_issued(input int n);
    int k = 0;
    while (issued_cnt != 16'(n) && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("issued_cnt", 64'(issued_cnt), 64'(n));
    chk("sb_drained", 64'(exp_q.size()), 64'd0);
  endtask

  // accelerator: take each offered set and stay busy 3 cycles
  initial begin
    forever begin
      @(negedge clk);
      if (auto_en && cfg_valid && rst_n) begin
        acc_busy = 1'b1;
        repeat (3) @(negedge clk);
        acc_busy = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && cfg_valid && !prev_v) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected", 64'd1, 64'd0);
      end else begin
        cfg_set_t e;
        e = exp_q.pop_front();
        chk("sb_data", cfg_data_data, e.data);
        chk("sb_wicp", cfg_wicp_data, e.wicp);
        chk("sb_tmpc", 64'(cfg_tmpc_data), 64'(e.tmpc));
        chk("sb_post", 64'(cfg_post_data), 64'(e.post));
      end
    end
    prev_v = rst_n ? cfg_valid : 1'b0;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst_n       = 1'b0;
    host_wvalid = 1'b0;
    host_wlast  = 1'b0;
    host_wsel   = 2'd0;
    host_wdata  = '0;
    m_set       = '0;
    prev_v      = 1'b0;
    for (int i = 0; i < 4; i++) m_idx[i] = 0;
    #22;
    chk("rst_valid", 64'(cfg_valid), 64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("rst_issued", 64'(issued_cnt), 64'd0);
    chk("rst_ovf", 64'(err_overflow), 64'd0);
    chk("rst_data", cfg_data_data, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_wready", 64'(host_wready), 64'd1);

    // single set with commit-to-valid latency
    send_beat(2'd0, 32'h11111111, 1'b0);
    send_beat(2'd0, 32'h22222222, 1'b0);
    send_beat(2'd1, 32'h0000000A, 1'b0);
    send_beat(2'd1, 32'h0000000B, 1'b0);
    send_beat(2'd2, 32'h0000000C, 1'b0);
    send_beat(2'd3, 32'h0000000D, 1'b1);
    @(negedge clk);
    chk("lat_t1_valid", 64'(cfg_valid), 64'd0);
    @(negedge clk);
    chk("lat_t2_valid", 64'(cfg_valid), 64'd1);
    chk("single_data", cfg_data_data, 64'h2222222211111111);
    chk("single_post", 64'(cfg_post_data), 64'hD);
    wait_issued(1);

    // partial update: only POST rewritten
    send_beat(2'd3, 32'h5, 1'b1);
    wait_issued(2);

    // overflow on TMPC, sticky across commits
    send_beat(2'd2, 32'h100, 1'b0);
    chk("ovf_before", 64'(err_overflow), 64'd0);
    send_beat(2'd2, 32'h200, 1'b0);
    send_beat(2'd2, 32'h300, 1'b0);
    chk("ovf_set", 64'(err_overflow), 64'd1);
    send_beat(2'd3, 32'h6, 1'b1);
    wait_issued(3);
    chk("ovf_sticky", 64'(err_overflow), 64'd1);

    // fill with accelerator busy, then drain in order
    hold_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_beat(2'd0, 32'h1000 + 32'(i), 1'b0);
      send_beat(2'd0, 32'h2000 + 32'(i), 1'b1);
    end
    @(negedge clk);
    chk("fill_level", 64'(fifo_level), 64'd4);
    chk("fill_wready", 64'(host_wready), 64'd0);
    hold_busy = 1'b0;
    @(negedge clk);
    chk("drain_level", 64'(fifo_level), 64'd3);
    chk("drain_wready", 64'(host_wready), 64'd1);
    wait_issued(7);

    // commit on the same edge as a pop
    hold_busy = 1'b1;
    send_beat(2'd3, 32'h77, 1'b1);
    @(negedge clk);
    hold_busy   = 1'b0;
    host_wvalid = 1'b1;
    host_wsel   = 2'd3;
    host_wdata  = 32'h88;
    host_wlast  = 1'b1;
    @(posedge clk);
    model_beat(2'd3, 32'h88, 1'b1);
    #1;
    host_wvalid = 1'b0;
    host_wlast  = 1'b0;
    @(negedge clk);
    chk("pushpop_level", 64'(fifo_level), 64'd1);
    chk("pushpop_valid", 64'(cfg_valid), 64'd1);
    wait_issued(9);

    // asynchronous reset while a set is offered
    auto_en = 1'b0;
    send_beat(2'd0, 32'h55, 1'b0);
    send_beat(2'd3, 32'h66, 1'b1);
    k = 0;
    while (!cfg_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("issue_reached", 64'(cfg_valid), 64'd1);
    send_beat(2'd3, 32'h99, 1'b1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(cfg_valid), 64'd0);
    chk("arst_level", 64'(fifo_level), 64'd0);
    chk("arst_issued", 64'(issued_cnt), 64'd0);
    chk("arst_ovf", 64'(err_overflow), 64'd0);
    exp_q.delete();
    m_set = '0;
    for (int i = 0; i < 4; i++) m_idx[i] = 0;
    @(negedge clk);
    rst_n   = 1'b1;
    auto_en = 1'b1;
    send_beat(2'd0, 32'hAB, 1'b0);
    send_beat(2'd3, 32'hCD, 1'b1);
    wait_issued(1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
